// File: rtl/dti_uart_clk_rst_ctrl_if.sv
// Control/status bundle between the APB register block and the UART clock/reset controller.
// DTI_UART_FRAC_DIV_EN adds the 4-bit fractional divisor field.
interface dti_uart_clk_rst_ctrl_if #(
  parameter int unsigned DIV_W = 16
);
  logic             sw_rst_req;
  logic             enable;
  logic [DIV_W-1:0] div_val;
  logic             div_wr;
`ifdef DTI_UART_FRAC_DIV_EN
  logic [3:0]       div_frac;
`endif
  logic             uart_rst;
  logic             ready;
  logic             tick_16x;
  logic             tick_1x;
  logic             div_pend;
  logic             div_err;

  modport master (
`ifdef DTI_UART_FRAC_DIV_EN
    output div_frac,
`endif
    output sw_rst_req, enable, div_val, div_wr,
    input  uart_rst, ready, tick_16x, tick_1x, div_pend, div_err
  );

  modport slave (
`ifdef DTI_UART_FRAC_DIV_EN
    input  div_frac,
`endif
    input  sw_rst_req, enable, div_val, div_wr,
    output uart_rst, ready, tick_16x, tick_1x, div_pend, div_err
  );
endinterface

// File: rtl/dti_uart_clk_rst_ctrl.sv
// UART reset sequencer and baud strobe generator (16x oversampling and 1x bit ticks).
// Define DTI_UART_FRAC_DIV_EN to enable the fractional (1/16) divisor accumulator.
module dti_uart_clk_rst_ctrl #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned RST_HOLD = 8,
  parameter int unsigned OVS      = 16
) (
  input logic                    apb_clk,
  input logic                    reset,
  dti_uart_clk_rst_ctrl_if.slave bus
);
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int unsigned OVS_W  = $clog2(OVS);

  localparam logic [0:0] StHold = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;

  logic             run, count_en, tick16, tick1;
  logic             wr_ok, apply;
  logic [DIV_W-1:0] new_div, next_div, reload;

  assign run      = (state_q == StRun);
  assign count_en = run && bus.enable;
  assign tick16   = count_en && (div_cnt_q == '0);
  assign tick1    = tick16 && (ovs_cnt_q == OVS_W'(OVS - 1));

  // A write coinciding with an apply window goes straight to the active divisor.
  assign wr_ok    = bus.div_wr && (bus.div_val != '0);
  assign apply    = (wr_ok || pend_q) && (!run || !bus.enable || bus.sw_rst_req || tick16);
  assign new_div  = wr_ok ? bus.div_val : pend_div_q;
  assign next_div = apply ? new_div : active_div_q;

`ifdef DTI_UART_FRAC_DIV_EN
  logic [3:0] active_frac_q, active_frac_d;
  logic [3:0] pend_frac_q, pend_frac_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] next_frac;
  logic [4:0] acc_sum;

  assign next_frac = apply ? (wr_ok ? bus.div_frac : pend_frac_q) : active_frac_q;
  assign acc_sum   = {1'b0, acc_q} + {1'b0, next_frac};
  // Carry stretches the coming period by one cycle.
  assign reload    = acc_sum[4] ? next_div : next_div - DIV_W'(1);
`else
  assign reload    = next_div - DIV_W'(1);
`endif

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    div_cnt_d    = div_cnt_q;
    ovs_cnt_d    = ovs_cnt_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    pend_d       = pend_q;
    err_d        = err_q;
`ifdef DTI_UART_FRAC_DIV_EN
    active_frac_d = active_frac_q;
    pend_frac_d   = pend_frac_q;
    acc_d         = acc_q;
`endif

    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        if (tick16) begin
          div_cnt_d = reload;
          ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
`ifdef DTI_UART_FRAC_DIV_EN
          acc_d     = acc_sum[3:0];
`endif
        end else if (count_en) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
    endcase

    if (apply) begin
      active_div_d = new_div;
      pend_d       = 1'b0;
`ifdef DTI_UART_FRAC_DIV_EN
      active_frac_d = next_frac;
`endif
    end else if (wr_ok) begin
      pend_d     = 1'b1;
      pend_div_d = bus.div_val;
`ifdef DTI_UART_FRAC_DIV_EN
      pend_frac_d = bus.div_frac;
`endif
    end

    if (bus.sw_rst_req) begin
      state_d    = StHold;
      hold_cnt_d = '0;
      div_cnt_d  = '0;
      ovs_cnt_d  = '0;
      err_d      = 1'b0;
`ifdef DTI_UART_FRAC_DIV_EN
      acc_d      = '0;
`endif
    end

    if (bus.div_wr && (bus.div_val == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge apb_clk) begin
    if (reset) begin
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      div_cnt_q    <= '0;
      ovs_cnt_q    <= '0;
      active_div_q <= DIV_W'(1);
      pend_div_q   <= '0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef DTI_UART_FRAC_DIV_EN
      active_frac_q <= '0;
      pend_frac_q   <= '0;
      acc_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      div_cnt_q    <= div_cnt_d;
      ovs_cnt_q    <= ovs_cnt_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
`ifdef DTI_UART_FRAC_DIV_EN
      active_frac_q <= active_frac_d;
      pend_frac_q   <= pend_frac_d;
      acc_q         <= acc_d;
`endif
    end
  end

  assign bus.uart_rst = !run;
  assign bus.ready    = run;
  assign bus.tick_16x = tick16;
  assign bus.tick_1x  = tick1;
  assign bus.div_pend = pend_q;
  assign bus.div_err  = err_q;
endmodule
